// File: rtl/if_fetch_pkg.sv
// Shared IF-stage definitions: FSM states and fixed instruction/word constants.
package if_fetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_RECV  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } fetch_state_t;

    // addi x0,x0,0
    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/if_fetch.sv
// IF stage: owns the PC, fetches one instruction as four byte reads through the
// byte-wide memory controller and holds it for the IF/ID register until accepted.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = NOP_WORD
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        pcreg_stall,
    input  logic        jump_en,
    input  logic [31:0] jump_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_byte_valid,
    input  logic [7:0]  mem_byte,
    output logic        if_stall,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [1:0]   cnt;
    logic [31:0]  asm_word;

    // cnt counts bytes of the single outstanding transfer, both while assembling
    // (S_RECV) and while discarding a killed transfer (S_DRAIN); cnt==3 is the last byte.
    // A redirect never writes asm_word, so drained bytes cannot leak into inst.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            cnt      <= '0;
            asm_word <= NOP_INST;
            inst_pc  <= ZERO_WORD;
        end else if (jump_en) begin
            pc <= jump_addr & ~32'h0000_0003;
            case (state)
                S_IDLE: state <= S_REQ;
                S_REQ: begin
                    if (mem_gnt) begin
                        state <= S_DRAIN;
                        cnt   <= '0;
                    end
                end
                S_RECV, S_DRAIN: begin
                    if (mem_byte_valid) begin
                        state <= (cnt == 2'd3) ? S_REQ : S_DRAIN;
                        cnt   <= cnt + 2'd1;
                    end else begin
                        state <= S_DRAIN;
                    end
                end
                S_DONE:  state <= S_REQ;
                default: state <= S_IDLE;
            endcase
        end else begin
            case (state)
                S_IDLE: state <= S_REQ;
                S_REQ: begin
                    if (mem_gnt) begin
                        state <= S_RECV;
                        cnt   <= '0;
                    end
                end
                S_RECV: begin
                    if (mem_byte_valid) begin
                        asm_word[{cnt, 3'b000} +: 8] <= mem_byte;
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state   <= S_DONE;
                            inst_pc <= pc;
                        end
                    end
                end
                S_DONE: begin
                    if (!pcreg_stall) begin
                        pc    <= pc + 32'd4;
                        state <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (mem_byte_valid) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) state <= S_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decoded from the registered state only
    assign mem_req    = (state == S_REQ);
    assign mem_addr   = mem_req ? pc : ZERO_WORD;
    assign if_stall   = (state != S_DONE);
    assign inst_valid = (state == S_DONE);
    assign inst       = inst_valid ? asm_word : NOP_INST;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: byte assembly, stall hold, redirects, drains, wrap, reset.
module tb_if_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        pcreg_stall;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_byte_valid;
    logic [7:0]  mem_byte;
    logic        if_stall;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int checks = 0;
    int errors = 0;

    if_fetch #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0013)) dut (
        .clk_in         (clk_in),
        .rst_n          (rst_n),
        .pcreg_stall    (pcreg_stall),
        .jump_en        (jump_en),
        .jump_addr      (jump_addr),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_gnt        (mem_gnt),
        .mem_byte_valid (mem_byte_valid),
        .mem_byte       (mem_byte),
        .if_stall       (if_stall),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        mem_byte_valid = 1'b1;
        mem_byte       = b;
        step();
        mem_byte_valid = 1'b0;
        mem_byte       = 8'h00;
    endtask

    task automatic grant();
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   {31'd0, mem_req},    32'd0);
        chk({tag, "_addr"},  mem_addr,            32'd0);
        chk({tag, "_stall"}, {31'd0, if_stall},   32'd1);
        chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
        chk({tag, "_inst"},  inst,                NOP);
        chk({tag, "_ipc"},   inst_pc,             32'd0);
    endtask

    initial begin
        rst_n          = 1'b0;
        pcreg_stall    = 1'b1;
        jump_en        = 1'b0;
        jump_addr      = 32'd0;
        mem_gnt        = 1'b0;
        mem_byte_valid = 1'b0;
        mem_byte       = 8'h00;
        step();
        step();
        chk_reset_outputs("rst");

        // 1: first fetch from RESET_PC
        rst_n = 1'b1;
        step();
        chk("t1_req", {31'd0, mem_req}, 32'd1);
        chk("t1_addr", mem_addr, 32'h0);
        grant();
        chk("t1_req_recv", {31'd0, mem_req}, 32'd0);
        send_byte(8'h13);
        send_byte(8'h05);
        send_byte(8'ha0);
        chk("t1_not_yet", {31'd0, inst_valid}, 32'd0);
        chk("t1_nop_partial", inst, NOP);
        send_byte(8'h00);
        chk("t1_inst", inst, 32'h00a00513);
        chk("t1_ipc", inst_pc, 32'h0);
        chk("t1_valid", {31'd0, inst_valid}, 32'd1);
        chk("t1_stall", {31'd0, if_stall}, 32'd0);

        // 2: held by pcreg_stall, then accepted
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_hold_inst", inst, 32'h00a00513);
            chk("t2_hold_ipc", inst_pc, 32'h0);
            chk("t2_hold_req", {31'd0, mem_req}, 32'd0);
        end
        pcreg_stall = 1'b0;
        step();
        pcreg_stall = 1'b1;
        chk("t2_addr", mem_addr, 32'h4);
        chk("t2_valid", {31'd0, inst_valid}, 32'd0);
        chk("t2_nop", inst, NOP);

        // 3: redirect to 0x103 after two bytes
        grant();
        send_byte(8'haa);
        send_byte(8'hbb);
        jump_en = 1'b1;
        jump_addr = 32'h0000_0103;
        step();
        jump_en = 1'b0;
        chk("t3_drain_req", {31'd0, mem_req}, 32'd0);
        send_byte(8'hcc);
        chk("t3_drain_req2", {31'd0, mem_req}, 32'd0);
        send_byte(8'hdd);
        chk("t3_req", {31'd0, mem_req}, 32'd1);
        chk("t3_addr", mem_addr, 32'h100);
        grant();
        send_byte(8'h93);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h00);
        chk("t3_inst", inst, 32'h00100093);
        chk("t3_ipc", inst_pc, 32'h100);
        pcreg_stall = 1'b0;
        step();
        pcreg_stall = 1'b1;
        chk("t3_next_addr", mem_addr, 32'h104);

        // 4: redirect coinciding with grant drains all four bytes
        jump_en = 1'b1;
        jump_addr = 32'h0000_0200;
        mem_gnt = 1'b1;
        step();
        jump_en = 1'b0;
        mem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_byte(8'hee);
            chk("t4_drain_req", {31'd0, mem_req}, 32'd0);
        end
        send_byte(8'hee);
        chk("t4_req", {31'd0, mem_req}, 32'd1);
        chk("t4_addr", mem_addr, 32'h200);
        // ungranted redirect retargets the pending request
        jump_en = 1'b1;
        jump_addr = 32'h0000_0300;
        step();
        jump_en = 1'b0;
        chk("t4_retarget_req", {31'd0, mem_req}, 32'd1);
        chk("t4_retarget_addr", mem_addr, 32'h300);

        // 5: bubbles of 0..3 cycles between bytes, then redirect in S_DONE
        grant();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] w;
            w = 32'h005002b3;
            for (int j = 0; j < i; j++) step();
            chk("t5_bubble_valid", {31'd0, inst_valid}, 32'd0);
            send_byte(w[8*i +: 8]);
        end
        chk("t5_inst", inst, 32'h005002b3);
        chk("t5_ipc", inst_pc, 32'h300);
        pcreg_stall = 1'b0;
        jump_en = 1'b1;
        jump_addr = 32'h0000_0400;
        step();
        jump_en = 1'b0;
        pcreg_stall = 1'b1;
        chk("t5_addr", mem_addr, 32'h400);
        chk("t5_valid", {31'd0, inst_valid}, 32'd0);
        chk("t5_nop", inst, NOP);

        // pc+4 wraps from the top word to zero
        jump_en = 1'b1;
        jump_addr = 32'hffff_ffff;
        step();
        jump_en = 1'b0;
        chk("wrap_addr", mem_addr, 32'hffff_fffc);
        grant();
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        chk("wrap_inst", inst, 32'h04030201);
        chk("wrap_ipc", inst_pc, 32'hffff_fffc);
        pcreg_stall = 1'b0;
        step();
        pcreg_stall = 1'b1;
        chk("wrap_next", mem_addr, 32'h0);

        // 6: asynchronous reset in the middle of a transfer
        grant();
        send_byte(8'h11);
        send_byte(8'h22);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t6");
        step();
        rst_n = 1'b1;
        chk("t6_idle_req", {31'd0, mem_req}, 32'd0);
        step();
        chk("t6_req", {31'd0, mem_req}, 32'd1);
        chk("t6_addr", mem_addr, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
